// File: rtl/demux_1to4_stream_32bit.sv
// Registered 1-to-4 valid/ready stream demultiplexer with a 1-entry holding register per channel.
// Optional per-channel load counters are enabled by defining DEMUX_STAT_EN.
module demux_1to4_stream_32bit #(
    parameter int unsigned width     = 32,
    parameter int unsigned cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [width-1:0]     i,
    input  logic [1:0]           sel,
    input  logic                 i_valid,
    output logic                 i_ready,
    output logic [width-1:0]     o0,
    output logic [width-1:0]     o1,
    output logic [width-1:0]     o2,
    output logic [width-1:0]     o3,
    output logic [3:0]           o_valid,
    input  logic [3:0]           o_ready
`ifdef DEMUX_STAT_EN
    ,
    output logic [cnt_width-1:0] cnt0,
    output logic [cnt_width-1:0] cnt1,
    output logic [cnt_width-1:0] cnt2,
    output logic [cnt_width-1:0] cnt3
`endif
);

    logic [width-1:0] data_q [4];
    logic [3:0]       valid_q;
    logic [3:0]       valid_d;
    logic [3:0]       load;
    logic [3:0]       drain;
    logic             in_xfer;

    // Ready depends only on the selected channel, never on the incoming data.
    always_comb begin
        i_ready = ~valid_q[sel] | o_ready[sel];
        in_xfer = i_valid & i_ready;
        load    = in_xfer ? (4'b0001 << sel) : 4'b0000;
        drain   = valid_q & o_ready;
        valid_d = (valid_q & ~drain) | load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    data_q[k] <= i;
                end
            end
        end
    end

    assign o0      = data_q[0];
    assign o1      = data_q[1];
    assign o2      = data_q[2];
    assign o3      = data_q[3];
    assign o_valid = valid_q;

`ifdef DEMUX_STAT_EN
    logic [cnt_width-1:0] cnt_q [4];

    // Counters wrap naturally at 2**cnt_width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    cnt_q[k] <= cnt_q[k] + 1'b1;
                end
            end
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];
`endif

endmodule
